// File: rtl/mt_thread_sched_if.sv
// Fetch-scheduler port bundle: execute-stage start/halt requests and fetch stall in,
// selected thread and active-thread status out.
interface mt_thread_sched_if #(
  parameter int unsigned NUM_THREADS  = 8,
  parameter int unsigned BITS_THREADS = $clog2(NUM_THREADS)
);
  logic                    stall_f;
  logic                    start_req_e;
  logic [BITS_THREADS-1:0] start_tid_e;
  logic                    halt_req_e;
  logic [BITS_THREADS-1:0] halt_tid_e;
  logic [BITS_THREADS-1:0] tid;
  logic                    tid_valid;
  logic [NUM_THREADS-1:0]  active_mask;
  logic [BITS_THREADS:0]   active_count;

  modport master (
    output stall_f, start_req_e, start_tid_e, halt_req_e, halt_tid_e,
    input  tid, tid_valid, active_mask, active_count
  );

  modport slave (
    input  stall_f, start_req_e, start_tid_e, halt_req_e, halt_tid_e,
    output tid, tid_valid, active_mask, active_count
  );
endinterface

// File: rtl/mt_thread_sched.sv
// Barrel-processor fetch thread scheduler: round-robin over active threads with a
// per-thread minimum re-issue gap so no thread has two instructions in the pipe.
module mt_thread_sched #(
  parameter int unsigned           NUM_THREADS  = 8,
  parameter int unsigned           BITS_THREADS = $clog2(NUM_THREADS),
  parameter int unsigned           MIN_GAP      = 5,
  parameter logic [NUM_THREADS-1:0] RESET_MASK  = NUM_THREADS'(1)
) (
  input  logic              clk,
  input  logic              rst,
  mt_thread_sched_if.slave  bus
);

  localparam int unsigned      GAP_W    = 4;
  localparam int unsigned      CNT_W    = BITS_THREADS + 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  logic [NUM_THREADS-1:0]  r_active_mask;
  logic [GAP_W-1:0]        r_gap [NUM_THREADS];
  logic [BITS_THREADS-1:0] r_tid;
  logic [BITS_THREADS-1:0] r_last_tid;
  logic                    r_tid_valid;

  logic [NUM_THREADS-1:0]  w_start_oh;
  logic [NUM_THREADS-1:0]  w_halt_oh;
  logic [NUM_THREADS-1:0]  w_eff_mask;
  logic [NUM_THREADS-1:0]  w_next_mask;
  logic [NUM_THREADS-1:0]  w_eligible;
  logic [BITS_THREADS-1:0] w_sel;
  logic [BITS_THREADS-1:0] w_idx;
  logic                    w_found;
  logic [CNT_W-1:0]        w_count;

  // A same-cycle halt removes its thread from selection immediately; halt beats start.
  always_comb begin
    w_start_oh = '0;
    w_halt_oh  = '0;
    if (bus.start_req_e) w_start_oh[bus.start_tid_e] = 1'b1;
    if (bus.halt_req_e)  w_halt_oh[bus.halt_tid_e]   = 1'b1;
    w_eff_mask  = r_active_mask & ~w_halt_oh;
    w_next_mask = (r_active_mask | w_start_oh) & ~w_halt_oh;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      w_eligible[i] = w_eff_mask[i] & (r_gap[i] == '0);
    end
  end

  // Scan from farthest to nearest so the thread closest after last_tid wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last_tid;
    w_idx   = '0;
    for (int j = int'(NUM_THREADS); j >= 1; j--) begin
      w_idx = BITS_THREADS'((int'(r_last_tid) + j) % int'(NUM_THREADS));
      if (w_eligible[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      w_count = w_count + CNT_W'(r_active_mask[i]);
    end
  end

  // Mask follows requests even while fetch is stalled; issue state freezes on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active_mask <= RESET_MASK;
      r_tid         <= '0;
      r_tid_valid   <= 1'b0;
      r_last_tid    <= BITS_THREADS'(NUM_THREADS - 1);
      for (int i = 0; i < int'(NUM_THREADS); i++) begin
        r_gap[i] <= '0;
      end
    end else begin
      r_active_mask <= w_next_mask;
      if (!bus.stall_f) begin
        r_tid_valid <= w_found;
        if (w_found) begin
          r_tid      <= w_sel;
          r_last_tid <= w_sel;
        end
        for (int i = 0; i < int'(NUM_THREADS); i++) begin
          if (w_found && (BITS_THREADS'(i) == w_sel)) begin
            r_gap[i] <= GAP_LOAD;
          end else if (r_gap[i] != '0) begin
            r_gap[i] <= r_gap[i] - GAP_W'(1);
          end
        end
      end
    end
  end

  assign bus.tid          = r_tid;
  assign bus.tid_valid    = r_tid_valid;
  assign bus.active_mask  = r_active_mask;
  assign bus.active_count = w_count;

endmodule

// File: tb/tb_mt_thread_sched.sv
// Self-checking bench for mt_thread_sched: directed scenarios plus randomized
// start/halt/stall traffic compared against a thread-level reference model.
module tb_mt_thread_sched;

  localparam int N       = 8;
  localparam int MIN_GAP = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mt_thread_sched_if #(.NUM_THREADS(8), .BITS_THREADS(3)) bus ();

  mt_thread_sched #(
    .NUM_THREADS(8), .BITS_THREADS(3), .MIN_GAP(5), .RESET_MASK(8'h01)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: thread-level state as plain integers.
  int m_act [N];
  int m_gap [N];
  int m_last;
  int m_tid;
  bit m_valid;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [7:0] model_mask();
    logic [7:0] m;
    for (int i = 0; i < N; i++) m[i] = (m_act[i] != 0);
    return m;
  endfunction

  function automatic logic [3:0] model_count();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (m_act[i] != 0) c++;
    return 4'(c);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = (i == 0) ? 1 : 0;
      m_gap[i] = 0;
    end
    m_last  = N - 1;
    m_tid   = 0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit stall, input bit sreq, input int stid,
                            input bit hreq, input int htid);
    int sel;
    int idx;
    sel = -1;
    if (!stall) begin
      for (int j = 1; j <= N; j++) begin
        idx = (m_last + j) % N;
        if (sel < 0 && m_act[idx] != 0 && !(hreq && htid == idx) && m_gap[idx] == 0)
          sel = idx;
      end
      for (int i = 0; i < N; i++) begin
        if (i == sel) m_gap[i] = MIN_GAP - 1;
        else if (m_gap[i] > 0) m_gap[i] = m_gap[i] - 1;
      end
      if (sel >= 0) begin
        m_tid   = sel;
        m_last  = sel;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (sreq) m_act[stid] = 1;
    if (hreq) m_act[htid] = 0;
  endtask

  // Drive one cycle of inputs at negedge, advance the model at posedge, settle #1.
  task automatic step(input bit stall, input bit sreq, input int stid,
                      input bit hreq, input int htid);
    @(negedge clk);
    bus.stall_f     = stall;
    bus.start_req_e = sreq;
    bus.start_tid_e = 3'(stid);
    bus.halt_req_e  = hreq;
    bus.halt_tid_e  = 3'(htid);
    @(posedge clk);
    model_edge(stall, sreq, stid, hreq, htid);
    #1;
  endtask

  task automatic test_reset();
    bus.stall_f = 1'b0; bus.start_req_e = 1'b0; bus.start_tid_e = '0;
    bus.halt_req_e = 1'b0; bus.halt_tid_e = '0;
    model_reset();
    #12;
    n_checks++;
    if (bus.tid !== 3'd0 || bus.tid_valid !== 1'b0 || bus.active_mask !== 8'h01 ||
        bus.active_count !== 4'd1) begin
      n_errors++;
      $display("FAIL reset: tid=%0d v=%b mask=%h cnt=%0d, want tid=0 v=0 mask=01 cnt=1",
               bus.tid, bus.tid_valid, bus.active_mask, bus.active_count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_single_thread();
    bit ev;
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 0, 0, 0);
      ev = (k % 5 == 1);
      n_checks++;
      if (bus.tid !== 3'd0 || bus.tid_valid !== ev || bus.tid_valid !== m_valid) begin
        n_errors++;
        $display("FAIL single_thread edge %0d: tid=%0d v=%b, want tid=0 v=%b",
                 k, bus.tid, bus.tid_valid, ev);
      end
    end
  endtask

  task automatic test_start_all();
    int p;
    for (int t = 1; t < N; t++) begin
      step(0, 1, t, 0, 0);
      n_checks++;
      if (bus.tid !== 3'(m_tid) || bus.tid_valid !== m_valid || bus.active_mask !== model_mask()) begin
        n_errors++;
        $display("FAIL start_all start %0d: tid=%0d v=%b mask=%h, want tid=%0d v=%b mask=%h",
                 t, bus.tid, bus.tid_valid, bus.active_mask, m_tid, m_valid, model_mask());
      end
    end
    for (int k = 0; k < 20; k++) begin
      p = m_tid;
      step(0, 0, 0, 0, 0);
      if (k >= 4) begin
        n_checks++;
        if (bus.tid !== 3'((p + 1) % N) || bus.tid_valid !== 1'b1) begin
          n_errors++;
          $display("FAIL start_all rr %0d: tid=%0d v=%b, want tid=%0d v=1",
                   k, bus.tid, bus.tid_valid, (p + 1) % N);
        end
      end
    end
    n_checks++;
    if (bus.active_mask !== 8'hFF || bus.active_count !== 4'd8) begin
      n_errors++;
      $display("FAIL start_all mask: mask=%h cnt=%0d, want mask=ff cnt=8",
               bus.active_mask, bus.active_count);
    end
  endtask

  task automatic test_halt();
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 16 && !hit; k++) begin
      if (m_tid == 2 && m_valid) hit = 1'b1;
      else step(0, 0, 0, 0, 0);
    end
    n_checks++;
    if (!hit || bus.tid !== 3'd2) begin
      n_errors++;
      $display("FAIL halt_sync: tid=%0d, want tid=2 within 16 cycles", bus.tid);
    end
    step(0, 0, 0, 1, 3);
    n_checks++;
    if (bus.tid !== 3'd4 || bus.tid_valid !== 1'b1 || bus.active_mask !== 8'hF7) begin
      n_errors++;
      $display("FAIL halt_skip: tid=%0d v=%b mask=%h, want tid=4 v=1 mask=f7",
               bus.tid, bus.tid_valid, bus.active_mask);
    end
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 0, 0);
      n_checks++;
      if ((bus.tid_valid === 1'b1 && bus.tid === 3'd3) || bus.tid !== 3'(m_tid) ||
          bus.tid_valid !== m_valid) begin
        n_errors++;
        $display("FAIL halt_after %0d: tid=%0d v=%b, want tid=%0d v=%b (never 3)",
                 k, bus.tid, bus.tid_valid, m_tid, m_valid);
      end
    end
  endtask

  task automatic test_two_threads();
    bit hit;
    bit ev [5];
    int et [5];
    ev = '{1, 0, 0, 0, 1};
    et = '{1, 1, 1, 1, 0};
    for (int t = 2; t < N; t++) if (t != 3) step(0, 0, 0, 1, t);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      step(0, 0, 0, 0, 0);
      if (bus.tid === 3'd0 && bus.tid_valid === 1'b1) hit = 1'b1;
    end
    n_checks++;
    if (!hit || bus.active_mask !== 8'h03) begin
      n_errors++;
      $display("FAIL two_sync: found=%b mask=%h, want found=1 mask=03", hit, bus.active_mask);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0);
      n_checks++;
      if (bus.tid !== 3'(et[k]) || bus.tid_valid !== ev[k]) begin
        n_errors++;
        $display("FAIL two_pattern %0d: tid=%0d v=%b, want tid=%0d v=%b",
                 k, bus.tid, bus.tid_valid, et[k], ev[k]);
      end
    end
  endtask

  task automatic test_stall();
    int ft;
    for (int t = 2; t < N; t++) if (t != 6) step(0, 1, t, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.active_mask !== 8'hBF || bus.tid_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_pre: mask=%h v=%b, want mask=bf v=1", bus.active_mask, bus.tid_valid);
    end
    ft = m_tid;
    for (int k = 0; k < 4; k++) begin
      step(1, (k == 0), 6, 0, 0);
      n_checks++;
      if (bus.tid !== 3'(ft) || bus.tid_valid !== 1'b1 || bus.active_mask !== 8'hFF) begin
        n_errors++;
        $display("FAIL stall_hold %0d: tid=%0d v=%b mask=%h, want tid=%0d v=1 mask=ff",
                 k, bus.tid, bus.tid_valid, bus.active_mask, ft);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0, 0);
      n_checks++;
      if (bus.tid !== 3'((ft + k) % N) || bus.tid_valid !== 1'b1 || bus.tid !== 3'(m_tid)) begin
        n_errors++;
        $display("FAIL stall_resume %0d: tid=%0d v=%b, want tid=%0d v=1",
                 k, bus.tid, bus.tid_valid, (ft + k) % N);
      end
    end
  endtask

  task automatic test_start_halt_same();
    step(0, 1, 5, 1, 5);
    n_checks++;
    if (bus.active_mask !== 8'hDF || bus.active_count !== 4'd7) begin
      n_errors++;
      $display("FAIL same_tid: mask=%h cnt=%0d, want mask=df cnt=7", bus.active_mask, bus.active_count);
    end
    step(0, 1, 5, 1, 1);
    n_checks++;
    if (bus.active_mask !== 8'hFD || bus.active_count !== 4'd7) begin
      n_errors++;
      $display("FAIL diff_tid: mask=%h cnt=%0d, want mask=fd cnt=7", bus.active_mask, bus.active_count);
    end
  endtask

  task automatic test_all_zero();
    for (int t = 0; t < N; t++) step(0, 0, 0, 1, t);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0, 0);
      n_checks++;
      if (bus.tid_valid !== 1'b0 || bus.tid !== 3'(m_tid) || bus.active_mask !== 8'h00 ||
          bus.active_count !== 4'd0) begin
        n_errors++;
        $display("FAIL all_zero %0d: tid=%0d v=%b mask=%h cnt=%0d, want tid=%0d v=0 mask=00 cnt=0",
                 k, bus.tid, bus.tid_valid, bus.active_mask, bus.active_count, m_tid);
      end
    end
  endtask

  task automatic test_random();
    bit st, sr, hr;
    int sti, hti;
    for (int k = 0; k < 400; k++) begin
      st  = ($urandom % 5) == 0;
      sr  = ($urandom % 4) == 0;
      hr  = ($urandom % 7) == 0;
      sti = int'($urandom % N);
      hti = int'($urandom % N);
      step(st, sr, sti, hr, hti);
      n_checks++;
      if (bus.tid !== 3'(m_tid) || bus.tid_valid !== m_valid ||
          bus.active_mask !== model_mask() || bus.active_count !== model_count()) begin
        n_errors++;
        $display("FAIL random %0d: tid=%0d v=%b mask=%h cnt=%0d, want tid=%0d v=%b mask=%h cnt=%0d",
                 k, bus.tid, bus.tid_valid, bus.active_mask, bus.active_count,
                 m_tid, m_valid, model_mask(), model_count());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int t = 0; t < N; t++) step(0, 1, t, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.tid !== 3'd0 || bus.tid_valid !== 1'b0 || bus.active_mask !== 8'h01) begin
      n_errors++;
      $display("FAIL async_reset: tid=%0d v=%b mask=%h, want tid=0 v=0 mask=01",
               bus.tid, bus.tid_valid, bus.active_mask);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    n_checks++;
    if (bus.tid !== 3'd0 || bus.tid_valid !== 1'b1 || bus.active_mask !== 8'h01) begin
      n_errors++;
      $display("FAIL post_reset_issue: tid=%0d v=%b mask=%h, want tid=0 v=1 mask=01",
               bus.tid, bus.tid_valid, bus.active_mask);
    end
  endtask

  initial begin
    test_reset();
    test_single_thread();
    test_start_all();
    test_halt();
    test_two_threads();
    test_stall();
    test_start_halt_same();
    test_all_zero();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mt_thread_sched.md
Name: mt_thread_sched

Overview:
- Barrel-processor fetch thread scheduler. Each cycle it produces the tid that indexes the multi-threaded PC file (mt_pc) in the fetch stage.
- Tracks which hardware threads are active. Rotates round-robin over them.
- Enforces a minimum re-issue gap per thread, so one thread never has two instructions in flight inside the pipeline window when few threads are active.
- Start/halt requests arrive from the execute stage.

Parameters:
- NUM_THREADS, 8, number of hardware threads.
- BITS_THREADS, $clog2(NUM_THREADS), tid width.
- MIN_GAP, 5, minimum cycles between two issues of the same thread (pipeline depth); legal range 1..15.
- RESET_MASK, 8'h01, active-thread mask loaded at reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall_f  input  1  fetch stall; freezes scheduler state.
- start_req_e  input  1  activate thread start_tid_e.
- start_tid_e  input  BITS_THREADS  thread to activate.
- halt_req_e  input  1  deactivate thread halt_tid_e.
- halt_tid_e  input  BITS_THREADS  thread to deactivate.
- tid  output  BITS_THREADS  selected thread for fetch, registered.
- tid_valid  output  1  tid is a real issue slot; 0 = bubble.
- active_mask  output  NUM_THREADS  current active-thread mask, registered.
- active_count  output  BITS_THREADS+1  popcount of active_mask, combinational from the register.

Behaviour:
- Reset (rst=0, asynchronous):
  - tid=0, tid_valid=0, active_mask=RESET_MASK.
  - All gap counters=0.
  - last_tid=NUM_THREADS-1, so the first pick searches from thread 0.
- Per-thread gap counter: 4 bits.
- Halt masking:
  - eff_mask = active_mask with bit halt_tid_e cleared when halt_req_e=1.
  - A halt therefore excludes its thread from selection in the same cycle.
- Eligibility: eligible[i] = eff_mask[i] & (gap[i]==0).
- Selection:
  - Pick the first eligible thread scanning last_tid+1, last_tid+2, ..., wrapping modulo NUM_THREADS and ending at last_tid itself.
  - last_tid is eligible only if no other thread is.
- Rising edge with stall_f=0:
  - If a thread sel is found:
    - tid<=sel, tid_valid<=1, last_tid<=sel.
    - gap[sel]<=MIN_GAP-1.
    - All other nonzero gap counters decrement by 1.
  - If none is found:
    - tid holds, tid_valid<=0, last_tid holds.
    - Nonzero gap counters decrement.
- Rising edge with stall_f=1:
  - tid, tid_valid, last_tid and the gap counters all hold.
  - Start/halt still update active_mask.
- active_mask update, every edge regardless of stall:
  - Set bit start_tid_e if start_req_e.
  - Clear bit halt_tid_e if halt_req_e.
  - Same tid in both: halt wins, bit cleared.
  - Different tids: both apply.
- Start timing:
  - A start takes effect for selection on the cycle after it is registered.
  - Starting an already-active thread has no effect.
  - A newly started thread keeps its current gap counter; it is not reset.
- Halting the thread currently shown on tid does not retract that registered issue.
- Steady state:
  - With k active threads and k >= MIN_GAP, tid cycles strictly round-robin with tid_valid=1 every cycle.
  - With k < MIN_GAP, each thread issues every MIN_GAP cycles; bubbles fill the gap.
- MIN_GAP=1: the gap counter never blocks, giving pure round-robin.
- active_mask all zero: tid_valid=0 every cycle; tid holds its last value.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk. The first issue occurs on the first rising edge after rst deasserts.

Test Plan:
1. Defaults, rst released, no requests -> thread 0 only: tid=0 with tid_valid=1 on edges 1, 6, 11, ...; tid_valid=0 on the other edges.
2. start_req_e pulses for tids 1-7 (one per cycle), then 20 idle cycles -> active_mask=8'hFF, active_count=8, tid sequence 0,1,...,7,0,... with tid_valid=1 every cycle.
3. All 8 active, halt_req_e tid=3 in the cycle where 3 would be selected -> 3 is skipped (2 is followed by 4), active_mask=8'hF7, 3 never issues again.
4. Active mask 8'h03, MIN_GAP=5 -> pattern 0,1,bubble,bubble,bubble,0,1,...
5. stall_f=1 for 4 cycles mid-stream with all 8 active -> tid and tid_valid frozen; after release the sequence resumes at the next thread with no skip or repeat; a start_req_e issued during the stall is reflected in active_mask.
6. Same cycle start_req_e and halt_req_e on tid 5 -> bit 5 cleared. Reset asserted asynchronously mid-stream -> tid=0, tid_valid=0, active_mask=8'h01 before the next clk edge.
